// File: rtl/bus_timer.sv
// Bus-attached 32-bit interval timer: four word registers behind a cs_/as_ handshake,
// level irq raised when COUNTER reaches EXPR, optional periodic reload.
module bus_timer #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_,
   input  logic        as_,
   input  logic        rw,
   input  logic [1:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy_,
   output logic        irq
);

   localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t      state_q;
   logic [3:0]  wcnt_q;
   logic        rw_q;
   logic [1:0]  addr_q;
   logic [31:0] wdat_q;
   logic        rdy_q;
   logic [31:0] rd_q;

   logic [1:0]  ctrl_q, ctrl_d;
   logic        intr_q, intr_d;
   logic [31:0] expr_q, expr_d;
   logic [31:0] cnt_q, cnt_d;

   logic [1:0]  rd_sel;
   logic [31:0] rd_mux;
   logic        wr_en;
   logic        expire;

   // From IDLE with no wait states the address is still on the bus, not yet latched.
   always_comb begin
      rd_sel = (state_q == IDLE) ? addr : addr_q;
      rd_mux = '0;
      case (rd_sel)
         2'd0: rd_mux = {30'b0, ctrl_q};
         2'd1: rd_mux = {31'b0, intr_q};
         2'd2: rd_mux = expr_q;
         2'd3: rd_mux = cnt_q;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         rw_q    <= 1'b1;
         addr_q  <= '0;
         wdat_q  <= '0;
         rdy_q   <= 1'b1;
         rd_q    <= '0;
      end else begin
         rdy_q <= 1'b1;
         rd_q  <= '0;
         case (state_q)
            IDLE: begin
               if (!cs_ && !as_) begin
                  addr_q <= addr;
                  rw_q   <= rw;
                  wdat_q <= wr_data;
                  if (WAIT_N == 4'd0) begin
                     state_q <= ACK;
                     rdy_q   <= 1'b0;
                     rd_q    <= rw ? rd_mux : '0;
                  end else begin
                     state_q <= WAIT;
                     wcnt_q  <= WAIT_N;
                  end
               end
            end
            WAIT: begin
               if (wcnt_q == 4'd1) begin
                  state_q <= ACK;
                  rdy_q   <= 1'b0;
                  rd_q    <= rw_q ? rd_mux : '0;
               end else begin
                  wcnt_q <= wcnt_q - 4'd1;
               end
            end
            ACK:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Timer first, then a bus write overrides its register; expiry still reaches INTR.
   always_comb begin
      wr_en  = (state_q == ACK) && !rw_q;
      expire = ctrl_q[0] && (cnt_q == expr_q);
      ctrl_d = ctrl_q;
      intr_d = intr_q;
      expr_d = expr_q;
      cnt_d  = cnt_q;
      if (ctrl_q[0]) begin
         if (expire) begin
            intr_d = 1'b1;
            cnt_d  = '0;
            if (!ctrl_q[1]) ctrl_d[0] = 1'b0;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
      if (wr_en) begin
         case (addr_q)
            2'd0: ctrl_d = wdat_q[1:0];
            2'd1: intr_d = wdat_q[0] | expire;
            2'd2: expr_d = wdat_q;
            2'd3: cnt_d  = wdat_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q <= '0;
         intr_q <= 1'b0;
         expr_q <= '0;
         cnt_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         intr_q <= intr_d;
         expr_q <= expr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign rd_data = rd_q;
   assign rdy_    = rdy_q;
   assign irq     = intr_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: one instance with no wait states, one with three,
// sharing the bus and selected by their own cs_.
module tb_bus_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        as_, rw;
   logic [1:0]  addr;
   logic [31:0] wr_data;
   logic        cs0_, cs3_;
   logic [31:0] rd0, rd3;
   logic        rdy0_, rdy3_;
   logic        irq0, irq3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_timer #(.WAIT_CYCLES(0)) u_t0 (
      .clk(clk), .reset(reset), .cs_(cs0_), .as_(as_), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd0), .rdy_(rdy0_), .irq(irq0));

   bus_timer #(.WAIT_CYCLES(3)) u_t3 (
      .clk(clk), .reset(reset), .cs_(cs3_), .as_(as_), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd3), .rdy_(rdy3_), .irq(irq3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called 1ns after an edge; returns 1ns after the edge that ends the ACK cycle.
   task automatic bus(input bit i3, input bit rd, input logic [1:0] a,
                      input logic [31:0] d, output logic [31:0] q);
      int n;
      int lat;
      lat = i3 ? 5 : 2;
      cs0_ = i3; cs3_ = !i3; as_ = 1'b0; rw = rd; addr = a; wr_data = d;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (!(i3 ? rdy3_ : rdy0_)) break;
      end
      chk(i3 ? "lat3" : "lat0", 32'(n), 32'(lat));
      q = i3 ? rd3 : rd0;
      @(posedge clk);
      #1;
      as_ = 1'b1; cs0_ = 1'b1; cs3_ = 1'b1;
      chk("rdy_width", 32'(i3 ? rdy3_ : rdy0_), 32'd1);
   endtask

   task automatic wr(input bit i3, input logic [1:0] a, input logic [31:0] d);
      logic [31:0] q;
      bus(i3, 1'b0, a, d, q);
   endtask

   task automatic rd(input bit i3, input logic [1:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] q;
      bus(i3, 1'b1, a, 32'h0, q);
      chk(tag, q, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; as_ = 1'b1; cs0_ = 1'b1; cs3_ = 1'b1;
      rw = 1'b1; addr = 2'd0; wr_data = 32'h0;
      #12;
      chk("rst_rdy0", 32'(rdy0_), 32'd1);
      chk("rst_rd0",  rd0,        32'd0);
      chk("rst_irq0", 32'(irq0),  32'd0);
      chk("rst_rdy3", 32'(rdy3_), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;

      // reset values, zero-wait latency
      for (int i = 0; i < 4; i++) rd(1'b0, 2'(i), 32'h0, "rst_reg");

      // cs_ high: strobe ignored
      as_ = 1'b0;
      for (int i = 0; i < 3; i++) begin cyc(1); chk("cs_ignore", 32'(rdy0_), 32'd1); end
      as_ = 1'b1;
      cyc(1);

      // periodic, EXPR=4 -> period 5
      wr(1'b0, 2'd2, 32'd4);
      wr(1'b0, 2'd0, 32'd3);
      cyc(4); chk("per_irq_pre", 32'(irq0), 32'd0);
      cyc(1); chk("per_irq_1",   32'(irq0), 32'd1);
      wr(1'b0, 2'd1, 32'd0);
      chk("per_clr", 32'(irq0), 32'd0);
      cyc(2); chk("per_irq_pre2", 32'(irq0), 32'd0);
      cyc(1); chk("per_irq_2",    32'(irq0), 32'd1);
      rd(1'b0, 2'd3, 32'd0, "per_cnt0");
      wr(1'b0, 2'd0, 32'd0);
      wr(1'b0, 2'd3, 32'd0);
      wr(1'b0, 2'd1, 32'd0);

      // one-shot, EXPR=2
      wr(1'b0, 2'd2, 32'd2);
      wr(1'b0, 2'd0, 32'd1);
      cyc(2); chk("os_irq_pre", 32'(irq0), 32'd0);
      cyc(1); chk("os_irq",     32'(irq0), 32'd1);
      rd(1'b0, 2'd0, 32'd0, "os_ctrl");
      cyc(3);
      rd(1'b0, 2'd3, 32'd0, "os_cnt");
      wr(1'b0, 2'd1, 32'd0);
      chk("os_clr", 32'(irq0), 32'd0);

      // collisions with expiry
      wr(1'b0, 2'd2, 32'd4);
      wr(1'b0, 2'd0, 32'd3);
      cyc(3);
      wr(1'b0, 2'd1, 32'd0);
      chk("hw_set_wins", 32'(irq0), 32'd1);
      cyc(3);
      wr(1'b0, 2'd3, 32'h10);
      rd(1'b0, 2'd3, 32'h10, "cnt_bus_wins");
      wr(1'b0, 2'd0, 32'd0);
      rd(1'b0, 2'd0, 32'd0, "ctrl_stop");
      wr(1'b0, 2'd1, 32'd0);
      chk("intr_clr", 32'(irq0), 32'd0);
      wr(1'b0, 2'd1, 32'd1);
      chk("intr_sw_set", 32'(irq0), 32'd1);
      rd(1'b0, 2'd1, 32'd1, "intr_rd");
      wr(1'b0, 2'd1, 32'd0);

      // three wait states
      wr(1'b1, 2'd2, 32'hDEADBEEF);
      rd(1'b1, 2'd2, 32'hDEADBEEF, "w3_expr");
      rd(1'b0, 2'd2, 32'd4, "t0_expr_isolated");
      chk("t3_irq", 32'(irq3), 32'd0);

      // reset during WAIT
      cs3_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 2'd2; wr_data = 32'h55;
      cyc(1); chk("mid_wait_rdy", 32'(rdy3_), 32'd1);
      reset = 1'b0;
      cyc(1); chk("mid_rst_rdy_a", 32'(rdy3_), 32'd1);
      cyc(1); chk("mid_rst_rdy_b", 32'(rdy3_), 32'd1);
      as_ = 1'b1; cs3_ = 1'b1;
      reset = 1'b1;
      cyc(3); chk("post_rst_rdy", 32'(rdy3_), 32'd1);
      rd(1'b1, 2'd2, 32'd0, "post_rst_expr");
      wr(1'b1, 2'd3, 32'h123);
      rd(1'b1, 2'd3, 32'h123, "post_rst_cnt");
      rd(1'b0, 2'd2, 32'd0, "t0_post_rst_expr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
